// File: rtl/uart_div_ctrl_pkg.sv
// Shared FSM encoding and defaults for the UART divide controller.
package uart_div_ctrl_pkg;

  typedef enum logic [2:0] {
    GET_A  = 3'd0,
    GET_B  = 3'd1,
    DIV    = 3'd2,
    SEND_Q = 3'd3,
    WAIT_Q = 3'd4,
    SEND_R = 3'd5,
    WAIT_R = 3'd6
  } state_t;

  localparam int BIT_MAX_DEF = 8;

  function automatic logic is_send(input state_t s);
    return (s == SEND_Q) || (s == SEND_R);
  endfunction

endpackage

// File: rtl/uart_div_ctrl_serial_div.sv
// Iterative restoring divider: one quotient bit per cycle, MSB first, BIT_MAX cycles after start.
module uart_div_ctrl_serial_div #(
  parameter int BIT_MAX = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic [BIT_MAX-1:0] a_i,
  input  logic [BIT_MAX-1:0] b_i,
  output logic               done_o,
  output logic [BIT_MAX-1:0] quot_o,
  output logic [BIT_MAX-1:0] rem_o
);

  localparam int CNT_W = $clog2(BIT_MAX + 1);

  logic [BIT_MAX-1:0] rem_q, rem_d;
  logic [BIT_MAX-1:0] quot_q, quot_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [BIT_MAX:0]   trial;
  logic               ge;

  // quot_o/rem_o are the results of the step taken this cycle; on done_o they are final.
  always_comb begin
    trial  = {rem_q, quot_q[BIT_MAX-1]};
    ge     = (trial >= {1'b0, b_i});
    rem_o  = ge ? BIT_MAX'(trial - {1'b0, b_i}) : trial[BIT_MAX-1:0];
    quot_o = {quot_q[BIT_MAX-2:0], ge};
    done_o = (cnt_q == CNT_W'(1));
    rem_d  = rem_q;
    quot_d = quot_q;
    cnt_d  = cnt_q;
    if (start_i) begin
      rem_d  = '0;
      quot_d = a_i;
      cnt_d  = CNT_W'(BIT_MAX);
    end else if (cnt_q != '0) begin
      rem_d  = rem_o;
      quot_d = quot_o;
      cnt_d  = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    rem_q  <= rem_d;
    quot_q <= quot_d;
  end

endmodule

// File: rtl/uart_div_ctrl.sv
// Collects dividend/divisor words from uart_rx, divides, and hands quotient (and remainder)
// to uart_tx through a start/busy handshake.
module uart_div_ctrl
  import uart_div_ctrl_pkg::*;
#(
  parameter int                 BIT_MAX  = BIT_MAX_DEF,
  parameter bit                 SEND_REM = 1'b1,
  parameter logic [BIT_MAX-1:0] DZ_CODE  = '1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rx_ready,
  input  logic [BIT_MAX-1:0] rx_data,
  input  logic               tx_busy,
  output logic               tx_start,
  output logic [BIT_MAX-1:0] tx_data,
  output logic               busy,
  output logic               div_err,
  output logic               overrun
);

  state_t             state_q, state_d;
  logic [BIT_MAX-1:0] ra_q, ra_d, rb_q, rb_d;
  logic [BIT_MAX-1:0] rx_q, rx_d, rr_q, rr_d;
  logic [BIT_MAX-1:0] tx_data_q, tx_data_d;
  logic               tx_start_q, busy_q, busy_prev_q;
  logic               div_err_q, div_err_d, overrun_q, overrun_d;
  logic               div_start, div_done, accept;
  logic [BIT_MAX-1:0] div_quot, div_rem;

  uart_div_ctrl_serial_div #(.BIT_MAX(BIT_MAX)) u_div (
    .clk    (clk),
    .rst    (rst),
    .start_i(div_start),
    .a_i    (ra_q),
    .b_i    (rb_q),
    .done_o (div_done),
    .quot_o (div_quot),
    .rem_o  (div_rem)
  );

  // A word is taken only on a rising tx_busy, so a transmitter still busy from
  // an earlier frame when we enter SEND is not mistaken for an accept.
  assign accept = tx_busy & ~busy_prev_q;

  always_comb begin
    state_d   = state_q;
    ra_d      = ra_q;
    rb_d      = rb_q;
    rx_d      = rx_q;
    rr_d      = rr_q;
    tx_data_d = tx_data_q;
    div_err_d = 1'b0;
    div_start = 1'b0;
    overrun_d = overrun_q | (rx_ready & (state_q != GET_A) & (state_q != GET_B));
    unique case (state_q)
      GET_A: if (rx_ready) begin
        ra_d    = rx_data;
        state_d = GET_B;
      end
      GET_B: if (rx_ready) begin
        rb_d = rx_data;
        if (rx_data == '0) begin
          rx_d      = DZ_CODE;
          rr_d      = ra_q;
          tx_data_d = DZ_CODE;
          div_err_d = 1'b1;
          state_d   = SEND_Q;
        end else begin
          div_start = 1'b1;
          state_d   = DIV;
        end
      end
      DIV: if (div_done) begin
        rx_d      = div_quot;
        rr_d      = div_rem;
        tx_data_d = div_quot;
        state_d   = SEND_Q;
      end
      SEND_Q: if (accept) state_d = WAIT_Q;
      WAIT_Q: if (!tx_busy) begin
        if (SEND_REM) begin
          tx_data_d = rr_q;
          state_d   = SEND_R;
        end else begin
          state_d = GET_A;
        end
      end
      SEND_R: if (accept) state_d = WAIT_R;
      WAIT_R: if (!tx_busy) state_d = GET_A;
      default: state_d = GET_A;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= GET_A;
      ra_q        <= '0;
      rb_q        <= '0;
      rx_q        <= '0;
      rr_q        <= '0;
      tx_data_q   <= '0;
      tx_start_q  <= 1'b0;
      busy_q      <= 1'b0;
      busy_prev_q <= 1'b0;
      div_err_q   <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ra_q        <= ra_d;
      rb_q        <= rb_d;
      rx_q        <= rx_d;
      rr_q        <= rr_d;
      tx_data_q   <= tx_data_d;
      tx_start_q  <= is_send(state_d);
      busy_q      <= (state_d != GET_A);
      busy_prev_q <= tx_busy;
      div_err_q   <= div_err_d;
      overrun_q   <= overrun_d;
    end
  end

  assign tx_start = tx_start_q;
  assign tx_data  = tx_data_q;
  assign busy     = busy_q;
  assign div_err  = div_err_q;
  assign overrun  = overrun_q;

endmodule

// File: tb/tb_uart_div_ctrl.sv
// Scoreboard bench for uart_div_ctrl: 8-bit with remainder, 8-bit quotient-only, 16-bit.
module tb_uart_div_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       rx_ready, tx_busy, tx_start, busy, div_err, overrun;
  logic [7:0] rx_data, tx_data;
  logic       tx_busy_nr, tx_start_nr, busy_nr, div_err_nr, overrun_nr;
  logic [7:0] tx_data_nr;
  logic        rx_ready16, tx_busy16, tx_start16, busy16, div_err16, overrun16;
  logic [15:0] rx_data16, tx_data16;

  int total = 0;
  int bad   = 0;
  logic [7:0]  q8[$];
  logic [7:0]  qnr[$];
  logic [15:0] q16[$];
  logic        hold_busy = 1'b0;

  uart_div_ctrl #(.BIT_MAX(8), .SEND_REM(1'b1)) dut (
    .clk(clk), .rst(rst), .rx_ready(rx_ready), .rx_data(rx_data), .tx_busy(tx_busy),
    .tx_start(tx_start), .tx_data(tx_data), .busy(busy), .div_err(div_err), .overrun(overrun)
  );

  uart_div_ctrl #(.BIT_MAX(8), .SEND_REM(1'b0)) dut_nr (
    .clk(clk), .rst(rst), .rx_ready(rx_ready), .rx_data(rx_data), .tx_busy(tx_busy_nr),
    .tx_start(tx_start_nr), .tx_data(tx_data_nr), .busy(busy_nr), .div_err(div_err_nr),
    .overrun(overrun_nr)
  );

  uart_div_ctrl #(.BIT_MAX(16), .SEND_REM(1'b1)) dut16 (
    .clk(clk), .rst(rst), .rx_ready(rx_ready16), .rx_data(rx_data16), .tx_busy(tx_busy16),
    .tx_start(tx_start16), .tx_data(tx_data16), .busy(busy16), .div_err(div_err16),
    .overrun(overrun16)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Transmitter models: accept on tx_start while idle, stay busy a few cycles.
  initial begin : tx8_model
    int cnt;
    cnt = 0;
    tx_busy = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (rst) begin
        tx_busy = 1'b0; cnt = 0;
      end else if (hold_busy) begin
        tx_busy = 1'b1;
      end else if (cnt != 0) begin
        cnt--;
        if (cnt == 0) tx_busy = 1'b0;
      end else if (tx_busy) begin
        tx_busy = 1'b0;
      end else if (tx_start) begin
        if (q8.size() == 0) begin
          total++; bad++;
          $display("FAIL tx8_word: unexpected word %0d, expected none", tx_data);
        end else begin
          check("tx8_word", tx_data, q8.pop_front());
        end
        tx_busy = 1'b1; cnt = 3;
      end
    end
  end

  initial begin : txnr_model
    int cnt;
    cnt = 0;
    tx_busy_nr = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (rst) begin
        tx_busy_nr = 1'b0; cnt = 0;
      end else if (cnt != 0) begin
        cnt--;
        if (cnt == 0) tx_busy_nr = 1'b0;
      end else if (tx_start_nr) begin
        if (qnr.size() == 0) begin
          total++; bad++;
          $display("FAIL txnr_word: unexpected word %0d, expected none", tx_data_nr);
        end else begin
          check("txnr_word", tx_data_nr, qnr.pop_front());
        end
        tx_busy_nr = 1'b1; cnt = 2;
      end
    end
  end

  initial begin : tx16_model
    int cnt;
    cnt = 0;
    tx_busy16 = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (rst) begin
        tx_busy16 = 1'b0; cnt = 0;
      end else if (cnt != 0) begin
        cnt--;
        if (cnt == 0) tx_busy16 = 1'b0;
      end else if (tx_start16) begin
        if (q16.size() == 0) begin
          total++; bad++;
          $display("FAIL tx16_word: unexpected word %0d, expected none", tx_data16);
        end else begin
          check("tx16_word", tx_data16, q16.pop_front());
        end
        tx_busy16 = 1'b1; cnt = 3;
      end
    end
  end

  task automatic put8(input logic [7:0] w);
    @(negedge clk); rx_data = w; rx_ready = 1'b1;
    @(negedge clk); rx_ready = 1'b0;
  endtask

  // Send A then B; measure cycles from B's rx_ready to tx_start; optionally poke a stray byte.
  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic [7:0] eq,
                     input logic [7:0] er, input int exp_lat, input bit exp_dz, input bit inject);
    int lat;
    q8.push_back(eq);
    q8.push_back(er);
    qnr.push_back(eq);
    put8(a);
    @(negedge clk); rx_data = b; rx_ready = 1'b1;
    lat = 0;
    for (int n = 1; n <= 40 && lat == 0; n++) begin
      @(posedge clk); #1;
      if (n == 1) begin
        rx_ready = 1'b0;
        check("div_err_pulse", div_err, exp_dz);
      end
      if (inject && n == 3) begin rx_data = 8'h42; rx_ready = 1'b1; end
      if (inject && n == 4) rx_ready = 1'b0;
      if (tx_start) lat = n;
    end
    check("tx_start_latency", lat, exp_lat);
    @(posedge clk); #1;
    check("div_err_one_cycle", div_err, 1'b0);
  endtask

  task automatic wait_idle8(input string name);
    int n;
    n = 0;
    while ((busy || busy_nr || q8.size() != 0 || qnr.size() != 0) && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    check({name, "_busy_low"}, busy, 1'b0);
    check({name, "_nr_busy_low"}, busy_nr, 1'b0);
    check({name, "_q8_drained"}, q8.size(), 0);
    check({name, "_qnr_drained"}, qnr.size(), 0);
  endtask

  task automatic op16(input logic [15:0] a, input logic [15:0] b, input logic [15:0] eq,
                      input logic [15:0] er, input int exp_lat);
    int lat;
    int n;
    q16.push_back(eq);
    q16.push_back(er);
    @(negedge clk); rx_data16 = a; rx_ready16 = 1'b1;
    @(negedge clk); rx_ready16 = 1'b0;
    @(negedge clk); rx_data16 = b; rx_ready16 = 1'b1;
    lat = 0;
    for (int k = 1; k <= 60 && lat == 0; k++) begin
      @(posedge clk); #1;
      if (k == 1) rx_ready16 = 1'b0;
      if (tx_start16) lat = k;
    end
    check("tx16_latency", lat, exp_lat);
    n = 0;
    while ((busy16 || q16.size() != 0) && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    check("tx16_busy_low", busy16, 1'b0);
    check("tx16_q_drained", q16.size(), 0);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    rst = 1'b1;
    rx_ready = 1'b0; rx_data = '0;
    rx_ready16 = 1'b0; rx_data16 = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_tx_start", tx_start, 1'b0);
    check("rst_tx_data", tx_data, 8'd0);
    check("rst_busy", busy, 1'b0);
    check("rst_div_err", div_err, 1'b0);
    check("rst_overrun", overrun, 1'b0);
    @(negedge clk); rst = 1'b0;

    op8(8'd100, 8'd7, 8'd14, 8'd2, 9, 1'b0, 1'b0);
    wait_idle8("q100_7");
    op8(8'd255, 8'd1, 8'd255, 8'd0, 9, 1'b0, 1'b0);
    wait_idle8("q255_1");
    op8(8'd3, 8'd10, 8'd0, 8'd3, 9, 1'b0, 1'b0);
    wait_idle8("q3_10");
    check("no_overrun_yet", overrun, 1'b0);

    op8(8'd5, 8'd0, 8'hFF, 8'd5, 1, 1'b1, 1'b0);
    wait_idle8("q5_0");

    op8(8'd100, 8'd7, 8'd14, 8'd2, 9, 1'b0, 1'b1);
    wait_idle8("overrun_100_7");
    check("overrun_set", overrun, 1'b1);
    check("overrun_set_nr", overrun_nr, 1'b1);
    op8(8'd200, 8'd9, 8'd22, 8'd2, 9, 1'b0, 1'b0);
    wait_idle8("after_overrun");
    check("overrun_sticky", overrun, 1'b1);

    @(negedge clk); hold_busy = 1'b1;
    op8(8'd100, 8'd7, 8'd14, 8'd2, 9, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      check("held_tx_start", tx_start, 1'b1);
      check("held_tx_data", tx_data, 8'd14);
    end
    @(negedge clk); hold_busy = 1'b0;
    wait_idle8("held_release");
    check("tx_data_holds_last", tx_data, 8'd2);

    put8(8'd50);
    @(negedge clk); rx_data = 8'd3; rx_ready = 1'b1;
    @(negedge clk); rx_ready = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check("mid_div_busy", busy, 1'b1);
    rst = 1'b1;
    #1;
    check("abort_tx_start", tx_start, 1'b0);
    check("abort_tx_data", tx_data, 8'd0);
    check("abort_busy", busy, 1'b0);
    check("abort_div_err", div_err, 1'b0);
    check("abort_overrun", overrun, 1'b0);
    check("abort_busy_nr", busy_nr, 1'b0);
    @(negedge clk); rst = 1'b0;
    op8(8'd200, 8'd9, 8'd22, 8'd2, 9, 1'b0, 1'b0);
    wait_idle8("after_abort");

    op16(16'd60000, 16'd7, 16'd8571, 16'd3, 17);
    op16(16'd1000, 16'd0, 16'hFFFF, 16'd1000, 1);
    check("w16_overrun", overrun16, 1'b0);

    repeat (5) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
